// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage multiply unit: op encodings, FSM states, widths.
package alu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Magnitude of v when it is treated as signed and is negative; 2^31 stays representable unsigned.
  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic en);
    return (en && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_seq_32_if.sv
// Issue/writeback handshake bundle for mul_seq_32.
interface mul_seq_32_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/mul_step_add.sv
// One radix-2 shift-add step: conditional 33-bit add into the high half, then shift {c,s,lo} right.
module mul_step_add
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] mcand,
  output logic [XLEN-1:0] hi_next_c,
  output logic [XLEN-1:0] lo_next_c
);

  logic [XLEN:0] sum;

  always_comb begin
    sum = lo[0] ? ({1'b0, hi} + {1'b0, mcand}) : {1'b0, hi};
    {hi_next_c, lo_next_c} = {sum, lo[XLEN-1:1]};
  end

endmodule

// File: rtl/mul_seq_32.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU), one shift-add step per cycle.
// Optional MUL_EARLY_EXIT_EN: leave RUN once the remaining multiplier bits are all zero.
module mul_seq_32
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mul_seq_32_if.slave  bus
);

  mul_state_e       state_q, state_n;
  logic [1:0]       op_q, op_n;
  logic [XLEN-1:0]  mcand_q, mcand_n;
  logic [XLEN-1:0]  hi_q, hi_n;
  logic [XLEN-1:0]  lo_q, lo_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             neg_q, neg_n;
  logic [XLEN-1:0]  result_q, result_n;
  logic             out_valid_q, out_valid_n;
  logic             in_ready_q, in_ready_n;
  logic             busy_q, busy_n;

  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] aligned;
  logic              last_step;
  logic              a_signed, b_signed;
  logic [2*XLEN-1:0] prod, prod_s;

  mul_step_add u_step (
    .hi        (hi_q),
    .lo        (lo_q),
    .mcand     (mcand_q),
    .hi_next_c (step_hi),
    .lo_next_c (step_lo)
  );

`ifdef MUL_EARLY_EXIT_EN
  logic [XLEN-1:0]  rem_mask;
  logic [CNT_W-1:0] rem_cnt;

  // After this step cnt+1 multiplier bits are consumed; the rest sit in step_lo[30-cnt:0].
  always_comb begin
    rem_mask  = {XLEN{1'b1}} >> CNT_W'(cnt_q + CNT_W'(1));
    rem_cnt   = CNT_W'(XLEN - 1) - cnt_q;
    last_step = ((step_lo & rem_mask) == '0);
    aligned   = {step_hi, step_lo} >> rem_cnt;
  end
`else
  always_comb begin
    last_step = (cnt_q == CNT_W'(XLEN - 1));
    aligned   = {step_hi, step_lo};
  end
`endif

  // Sign handling for the accepted operands and the final product.
  always_comb begin
    a_signed = (bus.op == MUL_OP_MULH) || (bus.op == MUL_OP_MULHSU);
    b_signed = (bus.op == MUL_OP_MULH);
    prod     = {hi_q, lo_q};
    prod_s   = neg_q ? (~prod + (2*XLEN)'(1)) : prod;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_n     = state_q;
    op_n        = op_q;
    mcand_n     = mcand_q;
    hi_n        = hi_q;
    lo_n        = lo_q;
    cnt_n       = cnt_q;
    neg_n       = neg_q;
    result_n    = result_q;
    out_valid_n = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_n    = bus.op;
          mcand_n = abs_if(bus.a, a_signed);
          lo_n    = abs_if(bus.b, b_signed);
          hi_n    = '0;
          cnt_n   = '0;
          neg_n   = (a_signed & bus.a[XLEN-1]) ^ (b_signed & bus.b[XLEN-1]);
          state_n = RUN;
        end
      end
      RUN: begin
        {hi_n, lo_n} = last_step ? aligned : {step_hi, step_lo};
        cnt_n        = cnt_q + CNT_W'(1);
        if (last_step) state_n = DONE;
      end
      DONE: begin
        // First DONE cycle forms the signed product; afterwards hold until consumed.
        if (!out_valid_q) begin
          result_n    = (op_q == MUL_OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
          out_valid_n = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    in_ready_n = (state_n == IDLE);
    busy_n     = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= MUL_OP_MUL;
      mcand_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      op_q        <= op_n;
      mcand_q     <= mcand_n;
      hi_q        <= hi_n;
      lo_q        <= lo_n;
      cnt_q       <= cnt_n;
      neg_q       <= neg_n;
      result_q    <= result_n;
      out_valid_q <= out_valid_n;
      in_ready_q  <= in_ready_n;
      busy_q      <= busy_n;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mul_seq_32.sv
// Scoreboard bench for mul_seq_32: directed vectors, latency, backpressure and reset-abort checks.
module tb_mul_seq_32;
  import alu_pkg::*;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic ov_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_seq_32_if bus ();

  mul_seq_32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: latency checked when out_valid rises, result checked at the handshake.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid && !ov_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got result 0x%08h with empty scoreboard", bus.result);
      end else if (sb[0].lat >= 0) begin
        check({sb[0].name, "_latency"}, 32'(cyc - sb[0].acc), 32'(sb[0].lat));
      end
    end
    if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, bus.result, e.res);
    end
    ov_prev = bus.out_valid;
  end

  task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] r, input int lat_ee);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: in_ready got 0 required 1", nm);
      return;
    end
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op       = 2'($urandom);
    bus.a        = $urandom;
    bus.b        = $urandom;
    sb.push_back('{r, cyc, (EE ? lat_ee : 33), nm});
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: pending got %0d required 0", nm, sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = MUL_OP_MUL;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_in_ready",  32'(bus.in_ready),  32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_busy",      32'(bus.busy),      32'd0);
    check("reset_result",    bus.result,         32'h0);

    issue("mulhu_max", MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    check("busy_in_run", 32'(bus.busy), 32'd1);
    check("in_ready_in_run", 32'(bus.in_ready), 32'd0);
    issue("mul_m1x7",    MUL_OP_MUL,    32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 4);
    issue("mulh_m1x7",   MUL_OP_MULH,   32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 4);
    issue("mulhsu_m1x7", MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 4);
    issue("mulh_min_sq", MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    issue("mulhsu_min",  MUL_OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    issue("mulh_zero_neg", MUL_OP_MULH, 32'h0, 32'hFFFF_FFFB, 32'h0, 4);
    drain("vectors");

    // Backpressure: hold the result for 5 cycles while a new request is offered.
    bus.out_ready = 1'b0;
    issue("bp_mulhu", MUL_OP_MULHU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 6);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_out_valid_seen", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = MUL_OP_MUL;
      bus.a        = 32'd9;
      bus.b        = 32'd9;
      @(posedge clk); #1;
      check("bp_result_stable", bus.result, 32'h0000_0001);
      check("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
    check("bp_out_valid_after", 32'(bus.out_valid), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("bp_no_spurious_busy", 32'(bus.busy), 32'd0);
    if (sb.size() != 0) sb.delete();

    // Reset in the middle of RUN aborts the operation.
    issue("aborted", MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    check("abort_result",    bus.result,         32'h0);
    check("abort_busy",      32'(bus.busy),      32'd0);
    issue("mul_3x5", MUL_OP_MUL, 32'd3, 32'd5, 32'd15, 4);
    drain("after_abort");

    // Small multipliers: early-exit latencies when the feature is built in.
    issue("mulhu_x0",   MUL_OP_MULHU, 32'h1234_5678, 32'h0, 32'h0, 2);
    issue("mul_10000x3", MUL_OP_MUL,  32'h0001_0000, 32'h3, 32'h0003_0000, 3);
    drain("early_exit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq_32.md
Name: mul_seq_32

Overview:
- Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU ops.
- Sits beside the ALU in execute: takes operands from issue and returns a 32-bit result to writeback.
- Each RUN cycle performs one 32-bit add with carry-out into the upper product half.
- valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  unit can accept; high only in IDLE
- op  in  2  00 MUL (low 32), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high)
- a  in  32  rs1 operand
- b  in  32  rs2 operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  product word selected by op
- busy  out  1  high in RUN or DONE

Behaviour:
- **Reset values** (rst sampled on a clk edge): state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; internal registers cleared.
  - rst has priority over every other input.
  - rst mid-RUN or mid-DONE aborts the operation; no result is ever presented.
- **Accept**: in_valid && in_ready at a clk edge.
  - Latch op.
  - Latch |a| if a is signed (MULH, MULHSU) and negative, else a.
  - Latch |b| if b is signed (MULH only) and negative, else b.
  - neg = sign(a)^sign(b), counting only operands that are signed.
  - Clear hi=0, load lo=multiplier magnitude, cnt=0.
  - Move to RUN.
- **RUN** (one step per cycle):
  - If lo[0]=1: {c,s}=hi+mcand (33-bit add), else {c,s}={0,hi}.
  - Then {hi,lo} <= {c,s,lo[31:1]}; cnt++.
  - When cnt==31 at the edge, move to DONE.
  - RUN lasts exactly 32 cycles.
- **Entering DONE**:
  - P = neg ? (~{hi,lo})+1 : {hi,lo}, computed as a 64-bit two's-complement negate.
  - result <= (op==MUL) ? P[31:0] : P[63:32].
  - out_valid <= 1.
- **Latency**: out_valid rises 33 edges after the accept edge.
- **DONE**: result and out_valid stay stable until out_valid && out_ready at an edge, then → IDLE.
  - in_ready returns high the cycle after that edge. The same-cycle accept/complete overlap is not supported.
- **Invariants**:
  - in_valid is ignored outside IDLE.
  - op/a/b may change freely after accept.
  - out_ready is ignored outside DONE.
- **Corner cases**:
  - MUL low word is identical for signed and unsigned encodings.
  - a=0x80000000, b=0x80000000 under MULH: magnitude 2^31 is held unsigned in 32 bits, so there is no overflow → 0x40000000.
  - Operand 0 with neg=1: negating 0 gives 0.

Optional Feature:
- **MUL_EARLY_EXIT_EN defined**: in RUN, if the remaining unprocessed multiplier bits are all zero, jump straight to the DONE entry step.
  - Shift {hi,lo} right by the remaining count 32-cnt to realign the product.
  - Latency becomes 2..33 edges, depending on the highest set bit of |multiplier|.
  - b=0 (after magnitude conversion) gives out_valid 2 edges after accept.
- **MUL_EARLY_EXIT_EN undefined**: fixed 33-edge latency, and no realignment shifter is synthesized.

Decomposition:
- **Shared package alu_pkg** holds:
  - Op encoding constants MUL_OP_MUL/MULH/MULHSU/MULHU.
  - State enum IDLE/RUN/DONE.
  - The XLEN constant.
- **Sub-module mul_step_add**: combinational single step.
  - Inputs: hi, lo, mcand.
  - Outputs: next {hi,lo}.
  - Contains the 33-bit add and the shift.
- FSM, counter, sign handling and handshake stay in mul_seq_32.

Test Plan:
- MULHU a=0xFFFFFFFF b=0xFFFFFFFF → result 0xFFFFFFFE; out_valid exactly 33 edges after accept (feature off).
- MUL a=0xFFFFFFFF(-1) b=7 → 0xFFFFFFF9; MULH same operands → 0xFFFFFFFF; MULHSU same operands → 0xFFFFFFFF.
- MULH a=0x80000000 b=0x80000000 → 0x40000000; MULHSU a=0x80000000 b=0xFFFFFFFF → 0x80000000.
- Backpressure: out_ready held low for 5 cycles in DONE → result stable, in_ready=0, a new in_valid is ignored; out_ready=1 → IDLE next edge.
- rst asserted at RUN cycle 10 → next edge: out_valid=0, in_ready=1, result=0; a following MUL 3×5 returns 15.
- With MUL_EARLY_EXIT_EN: MULHU 0x12345678×0 → result 0, latency 2 edges; MUL 0x10000×0x3 → 0x30000, latency 3 edges.
